// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width; the counter only has to reach WIDTH-1.
    function automatic int count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: two half-subtractor stages plus an OR on
// the stage borrows, the same shape as the full-adder cell.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic w_hs0_d;
    logic w_hs0_b;
    logic w_hs1_b;

    // First half subtractor: x - y.
    assign w_hs0_d = x ^ y;
    assign w_hs0_b = ~x & y;

    // Second half subtractor: (x - y) - bin.
    assign d       = w_hs0_d ^ bin;
    assign w_hs1_b = ~w_hs0_d & bin;

    assign bout    = w_hs0_b | w_hs1_b;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first.
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | one operand bit pair processed per edge
//   DONE  | result just registered, done asserted; start is accepted here
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int             CW   = count_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_bor;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_overflow;

    logic             w_d;
    logic             w_bout;
    logic             w_accept;
    logic             w_last;

    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
    assign w_last   = (r_state == SHIFT) && (r_count == LAST);

    full_subtractor u_cell (
        .x    (r_sa[0]),
        .y    (r_sb[0]),
        .bin  (r_bor),
        .d    (w_d),
        .bout (w_bout)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state decode; start is ignored while shifting.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = SHIFT;
            SHIFT:   if (r_count == LAST) w_state_next = DONE;
            DONE:    w_state_next = bus.start ? SHIFT : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, serial shifting, borrow chain and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_bor   <= 1'b0;
            r_count <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_accept) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_bor   <= 1'b0;
            r_count <= '0;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
        end else if (r_state == SHIFT) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_bor <= w_bout;
            // Hold on the last bit so a power-of-two WIDTH never wraps.
            if (!w_last) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Result registers change only on the completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_last) begin
            r_diff       <= {w_d, r_res[WIDTH-1:1]};
            r_borrow_out <= w_bout;
            r_overflow   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
        end
    end

    assign bus.busy       = (r_state == SHIFT);
    assign bus.done       = (r_state == DONE);
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases with literal results plus
// random traffic, all outputs checked every cycle against an arithmetic model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain unsigned/signed integer subtraction.
    function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] d, output logic bo, output logic ov);
        int sa, sb, sd;
        d  = W'(int'(a) - int'(b));
        bo = (int'(a) < int'(b));
        sa = (int'(a) >= 2**(W-1)) ? int'(a) - 2**W : int'(a);
        sb = (int'(b) >= 2**(W-1)) ? int'(b) - 2**W : int'(b);
        sd = sa - sb;
        ov = (sd > 2**(W-1) - 1) || (sd < -(2**(W-1)));
    endfunction

    // Behavioural model: an accepted request yields its result W edges later.
    int           m_rem;
    logic         m_done;
    logic [W-1:0] m_diff, p_diff;
    logic         m_bor, m_ovf, p_bor, p_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_diff = '0;
            m_bor  = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1'b1;
                m_diff = p_diff;
                m_bor  = p_bor;
                m_ovf  = p_ovf;
            end
        end else begin
            m_done = 1'b0;
            if (bus.start) begin
                ref_sub(bus.a, bus.b, p_diff, p_bor, p_ovf);
                m_rem = W;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",       32'(bus.busy),       32'(m_rem > 0));
            chk("done",       32'(bus.done),       32'(m_done));
            chk("diff",       32'(bus.diff),       32'(m_diff));
            chk("borrow_out", 32'(bus.borrow_out), 32'(m_bor));
            chk("overflow",   32'(bus.overflow),   32'(m_ovf));
        end
    end

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic ebo, input logic eov);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        wait_done(cyc);
        chk({name, "_latency"}, 32'(cyc), 32'(W));
        chk({name, "_diff"},    32'(bus.diff), 32'(ed));
        chk({name, "_borrow"},  32'(bus.borrow_out), 32'(ebo));
        chk({name, "_ovf"},     32'(bus.overflow), 32'(eov));
    endtask

    task automatic count_dones(input int n, output int nd);
        nd = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
    endtask

    initial begin
        int cyc, cyc2, gaps, nd;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_bor",  32'(bus.borrow_out), 32'd0);
        chk("rst_ovf",  32'(bus.overflow), 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        do_op("sub05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        do_op("sub03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        do_op("sub80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        do_op("sub7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Start while shifting must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            if (cyc == 3) begin
                bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("ignore_latency", 32'(cyc), 32'(W));
        chk("ignore_diff",    32'(bus.diff), 32'h0F);
        count_dones(12, nd);
        chk("ignore_no_extra_done", 32'(nd), 32'd0);

        // Back-to-back: start held through the DONE cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h05; bus.b = 8'h03;
        @(negedge clk);
        bus.a = 8'h00; bus.b = 8'h01;
        wait_done(cyc);
        chk("b2b_first_latency", 32'(cyc), 32'(W));
        chk("b2b_first_diff",    32'(bus.diff), 32'h02);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy_after_accept", 32'(bus.busy), 32'd1);
        cyc2 = 0;
        gaps = 0;
        while (!bus.done && cyc2 < 20) begin
            if (!bus.busy) gaps++;
            @(negedge clk);
            cyc2++;
        end
        chk("b2b_second_latency", 32'(cyc2), 32'(W));
        chk("b2b_busy_gaps",      32'(gaps), 32'd0);
        chk("b2b_second_diff",    32'(bus.diff), 32'hFF);
        chk("b2b_second_borrow",  32'(bus.borrow_out), 32'd1);
        chk("b2b_second_ovf",     32'(bus.overflow), 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_diff", 32'(bus.diff), 32'd0);
        chk("midrst_bor",  32'(bus.borrow_out), 32'd0);
        chk("midrst_ovf",  32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(12, nd);
        chk("midrst_no_done", 32'(nd), 32'd0);
        do_op("subAA_55", 8'hAA, 8'h55, 8'h55, 1'b0, 1'b1);

        // Random traffic; operands change every cycle since they are don't-care
        // outside the accepting edge.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
